// File: rtl/cond_flags_if.sv
// Interface bundle between the multicycle control FSM and the
// conditional-execution / status-flag stage.
// master: the controller side (drives the raw strobes, receives the gated enables).
// slave : cond_flags_unit.
interface cond_flags_if;
    logic       Decode;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       CondExReg;

    modport master (
        output Decode, Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        input  PCWrite, RegWrite, MemWrite, Flags, CondExReg
    );

    modport slave (
        input  Decode, Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        output PCWrite, RegWrite, MemWrite, Flags, CondExReg
    );
endinterface

// File: rtl/cond_flags_unit.sv
// Conditional-execution and status-flag stage of the multicycle ARM controller.
// Evaluates the condition field against the NZCV register during DECODE,
// latches the result for the rest of the instruction, and uses it to gate
// the PC, register-file, memory and flag writes.
// Optional build macro: COND_SQUASH_CNT_EN adds a saturating 16-bit count
// of instructions whose condition failed (SquashCount).
module cond_flags_unit (
    input  logic        clk,
    input  logic        reset,
`ifdef COND_SQUASH_CNT_EN
    output logic [15:0] SquashCount,
`endif
    cond_flags_if.slave bus
);

    logic [1:0] flags_nz;
    logic [1:0] flags_cv;
    logic       cond_ex;
    logic       cond_ex_reg;
    logic       n_flag, z_flag, c_flag, v_flag;

    assign n_flag = flags_nz[1];
    assign z_flag = flags_nz[0];
    assign c_flag = flags_cv[1];
    assign v_flag = flags_cv[0];

    // Condition check against the architectural flags (never against ALUFlags).
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = z_flag;
            4'b0001: cond_ex = ~z_flag;
            4'b0010: cond_ex = c_flag;
            4'b0011: cond_ex = ~c_flag;
            4'b0100: cond_ex = n_flag;
            4'b0101: cond_ex = ~n_flag;
            4'b0110: cond_ex = v_flag;
            4'b0111: cond_ex = ~v_flag;
            4'b1000: cond_ex = c_flag & ~z_flag;
            4'b1001: cond_ex = ~c_flag | z_flag;
            4'b1010: cond_ex = (n_flag == v_flag);
            4'b1011: cond_ex = (n_flag != v_flag);
            4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_ex = z_flag | (n_flag != v_flag);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Latch the condition result at the end of DECODE; holds for the whole instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cond_ex_reg <= 1'b0;
        else if (bus.Decode)
            cond_ex_reg <= cond_ex;
    end

    // N,Z half of the flag register; squashed by a failed condition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flags_nz <= 2'b00;
        else if (bus.FlagW[1] && cond_ex_reg)
            flags_nz <= bus.ALUFlags[3:2];
    end

    // C,V half of the flag register; independently enabled from N,Z.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flags_cv <= 2'b00;
        else if (bus.FlagW[0] && cond_ex_reg)
            flags_cv <= bus.ALUFlags[1:0];
    end

`ifdef COND_SQUASH_CNT_EN
    // Count instructions whose condition fails at DECODE, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            SquashCount <= 16'h0000;
        else if (bus.Decode && !cond_ex && (SquashCount != 16'hFFFF))
            SquashCount <= SquashCount + 16'h0001;
    end
`endif

    // Gated enables use only the latched result, so ALUFlags never reaches them.
    // NextPC is ungated so FETCH always advances the PC.
    assign bus.PCWrite   = bus.NextPC | (bus.PCS & cond_ex_reg);
    assign bus.RegWrite  = bus.RegW & cond_ex_reg;
    assign bus.MemWrite  = bus.MemW & cond_ex_reg;
    assign bus.Flags     = {flags_nz, flags_cv};
    assign bus.CondExReg = cond_ex_reg;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Directed bench for cond_flags_unit with hand-computed expected values.
module tb_cond_flags_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;
`ifdef COND_SQUASH_CNT_EN
    logic [15:0] SquashCount;
`endif

    cond_flags_if bus ();

    cond_flags_unit dut (
        .clk         (clk),
        .reset       (reset),
`ifdef COND_SQUASH_CNT_EN
        .SquashCount (SquashCount),
`endif
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Decode   = 1'b0;
        bus.Cond     = 4'b0000;
        bus.ALUFlags = 4'b0000;
        bus.FlagW    = 2'b00;
        bus.PCS      = 1'b0;
        bus.NextPC   = 1'b0;
        bus.RegW     = 1'b0;
        bus.MemW     = 1'b0;
    endtask

    task automatic decode(input logic [3:0] cond);
        bus.Decode = 1'b1;
        bus.Cond   = cond;
        step();
        bus.Decode = 1'b0;
    endtask

    // Force the flag register to a value via an always-executing flag-setting instruction.
    task automatic set_flags(input logic [3:0] v);
        decode(4'b1110);
        bus.FlagW    = 2'b11;
        bus.ALUFlags = v;
        step();
        bus.FlagW    = 2'b00;
        bus.ALUFlags = 4'b0000;
    endtask

    task automatic sweep(input string tag, input logic [15:0] exp);
        logic [15:0] got;
        got = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            decode(4'(i));
            got[i] = bus.CondExReg;
        end
        check_val(tag, got, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b0;
        idle_inputs();
        #3;
        check_val("rst_flags", {12'h0, bus.Flags}, 16'h0000);
        check_val("rst_condex", {15'h0, bus.CondExReg}, 16'h0000);
        bus.NextPC = 1'b1;
        bus.RegW   = 1'b1;
        bus.MemW   = 1'b1;
        #1;
        check_val("rst_pcwrite", {15'h0, bus.PCWrite}, 16'h0001);
        check_val("rst_regwrite", {15'h0, bus.RegWrite}, 16'h0000);
        check_val("rst_memwrite", {15'h0, bus.MemWrite}, 16'h0000);
        idle_inputs();
        step();
        reset = 1'b1;
        step();

        // AL executes
        decode(4'b1110);
        check_val("al_condex", {15'h0, bus.CondExReg}, 16'h0001);
        bus.RegW = 1'b1;
        #1;
        check_val("al_regwrite", {15'h0, bus.RegWrite}, 16'h0001);
        check_val("al_flags", {12'h0, bus.Flags}, 16'h0000);

        // Decode overlapping a write strobe uses the old latched result for that cycle
        bus.Decode = 1'b1;
        bus.Cond   = 4'b1111;
        #1;
        check_val("ovl_old_regwrite", {15'h0, bus.RegWrite}, 16'h0001);
        step();
        bus.Decode = 1'b0;
        check_val("ovl_new_regwrite", {15'h0, bus.RegWrite}, 16'h0000);
        bus.RegW = 1'b0;

        // EQ with Z=0 fails; NextPC still advances
        decode(4'b0000);
        check_val("eq_fail_condex", {15'h0, bus.CondExReg}, 16'h0000);
        bus.PCS  = 1'b1;
        bus.RegW = 1'b1;
        #1;
        check_val("eq_fail_pcwrite", {15'h0, bus.PCWrite}, 16'h0000);
        check_val("eq_fail_regwrite", {15'h0, bus.RegWrite}, 16'h0000);
        bus.NextPC = 1'b1;
        #1;
        check_val("nextpc_ungated", {15'h0, bus.PCWrite}, 16'h0001);
        idle_inputs();

        // Flag write in EXECUTE, visible next cycle, no effect on same instruction's CondExReg
        decode(4'b1110);
        bus.FlagW    = 2'b11;
        bus.ALUFlags = 4'b0110;
        step();
        bus.FlagW = 2'b00;
        check_val("fw11_flags", {12'h0, bus.Flags}, 16'h0006);
        check_val("fw11_condex_kept", {15'h0, bus.CondExReg}, 16'h0001);
        decode(4'b0000);
        check_val("eq_pass_condex", {15'h0, bus.CondExReg}, 16'h0001);
        bus.MemW = 1'b1;
        bus.PCS  = 1'b1;
        #1;
        check_val("eq_pass_memwrite", {15'h0, bus.MemWrite}, 16'h0001);
        check_val("eq_pass_pcwrite", {15'h0, bus.PCWrite}, 16'h0001);
        idle_inputs();

        // Failed GE squashes a flag write
        set_flags(4'b1000);
        check_val("set_1000", {12'h0, bus.Flags}, 16'h0008);
        decode(4'b1010);
        check_val("ge_fail_condex", {15'h0, bus.CondExReg}, 16'h0000);
        bus.FlagW    = 2'b11;
        bus.ALUFlags = 4'b0101;
        step();
        bus.FlagW = 2'b00;
        check_val("ge_fail_flags_kept", {12'h0, bus.Flags}, 16'h0008);

        // Independent halves
        set_flags(4'b0011);
        decode(4'b1110);
        bus.FlagW    = 2'b10;
        bus.ALUFlags = 4'b1111;
        step();
        check_val("fw10_flags", {12'h0, bus.Flags}, 16'h000F);
        bus.FlagW    = 2'b01;
        bus.ALUFlags = 4'b0000;
        step();
        check_val("fw01_flags", {12'h0, bus.Flags}, 16'h000C);
        idle_inputs();

        // Full condition table against three flag settings (bit i = result for Cond i)
        sweep("sweep_1100", 16'h6A99);
        set_flags(4'b0011);
        sweep("sweep_0011", 16'h6966);
        set_flags(4'b1001);
        sweep("sweep_1001", 16'h565A);

        // Reset mid-instruction drops pending writes at once
        decode(4'b1110);
        bus.RegW = 1'b1;
        bus.MemW = 1'b1;
        #1;
        check_val("pre_rst_regwrite", {15'h0, bus.RegWrite}, 16'h0001);
        reset = 1'b0;
        #1;
        check_val("mid_rst_regwrite", {15'h0, bus.RegWrite}, 16'h0000);
        check_val("mid_rst_memwrite", {15'h0, bus.MemWrite}, 16'h0000);
        check_val("mid_rst_condex", {15'h0, bus.CondExReg}, 16'h0000);
        check_val("mid_rst_flags", {12'h0, bus.Flags}, 16'h0000);
        idle_inputs();
        step();
        reset = 1'b1;
        step();

`ifdef COND_SQUASH_CNT_EN
        check_val("sq_reset", SquashCount, 16'h0000);
        decode(4'b1111);
        decode(4'b1110);
        decode(4'b1111);
        decode(4'b1111);
        check_val("sq_three", SquashCount, 16'h0003);
        decode(4'b1110);
        reset = 1'b0;
        #1;
        check_val("sq_async_clear", SquashCount, 16'h0000);
        check_val("sq_async_condex", {15'h0, bus.CondExReg}, 16'h0000);
        step();
        reset = 1'b1;
        step();
        bus.Decode = 1'b1;
        bus.Cond   = 4'b1111;
        for (int i = 0; i < 65535; i++) @(posedge clk);
        #1;
        check_val("sq_reach_max", SquashCount, 16'hFFFF);
        step();
        bus.Decode = 1'b0;
        check_val("sq_saturate", SquashCount, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cond_flags_unit.md
# cond_flags_unit

Conditional-execution and status-flag stage of the multicycle ARM controller. It sits directly downstream of the main control FSM and consumes its raw NextPC, RegW, MemW and Branch-derived PCS strobes. It also takes the ALU decoder's FlagW request. It qualifies these against the instruction's condition field and the architectural NZCV flags, producing the gated PCWrite, RegWrite and MemWrite enables sent to the datapath, and it holds the flag register itself.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- Decode  input  1  high for exactly the one cycle the FSM is in DECODE; the controller top derives it from the FSM state.
- Cond  input  4  Instr[31:28], stable from DECODE until the next FETCH.
- ALUFlags  input  4  {N,Z,C,V} from the ALU, same cycle.
- FlagW  input  2  ALU decoder request: bit1 writes N,Z; bit0 writes C,V.
- PCS  input  1  PC-source request: Branch, or Rd==15 with RegW.
- NextPC  input  1  unconditional PC update (FETCH).
- RegW  input  1  raw register-write strobe from the FSM.
- MemW  input  1  raw memory-write strobe from the FSM.
- PCWrite  output  1  gated PC enable.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated memory write enable.
- Flags  output  4  current {N,Z,C,V} register contents.
- CondExReg  output  1  latched condition result for the current instruction.

## Operation
- Condition check CondEx(Cond, Flags) is combinational:
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 MI: N.
  - 0101 PL: !N.
  - 0110 VS: V.
  - 0111 VC: !V.
  - 1000 HI: C&!Z.
  - 1001 LS: !C|Z.
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V).
  - 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: 0 (never executes).
- CondExReg loads CondEx on the rising edge ending a cycle with Decode=1. Otherwise it holds. The result therefore uses the flags as they stood before the instruction executes.
- Flag register has two independently enabled halves:
  - NZ = ALUFlags[3:2] when FlagW[1]&CondExReg.
  - CV = ALUFlags[1:0] when FlagW[0]&CondExReg.
- Gated outputs, all combinational:
  - PCWrite = NextPC | (PCS & CondExReg).
  - RegWrite = RegW & CondExReg.
  - MemWrite = MemW & CondExReg.
- NextPC is never gated, so FETCH always advances the PC.
- A failed condition squashes every write of that instruction: register, memory, branch and flags.

## Timing
- Reset values (async, while reset=0): Flags=4'b0000, CondExReg=0. Consequently PCWrite=NextPC, RegWrite=0, MemWrite=0.
- CondExReg is valid from the cycle after DECODE (EXECUTE, MEMADR or BRANCH state) through the end of the instruction.
- Flags written in an EXECUTE cycle are visible on Flags in the following ALUWB cycle. They do not alter CondExReg of the same instruction.
- FlagW=2'b11 with the condition passing updates both halves on the same edge.
- FlagW nonzero while Decode=1 is illegal. The block still applies the rule using the old CondExReg; the bench treats it as out of contract.
- Decode=1 while PCS/RegW/MemW is also high: the outputs use the old CondExReg for that cycle.
- Reset asserted mid-instruction clears CondExReg at once, so any pending RegWrite/MemWrite drops in the same cycle.
- No combinational path from ALUFlags to the write enables. The only path to the enables is from Cond through the register.

## Configuration
- COND_SQUASH_CNT_EN defined:
  - Adds output SquashCount[15:0], reset to 0.
  - Increments on each Decode cycle whose CondEx evaluates 0.
  - Saturates at 16'hFFFF; no wrap.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release, then Decode with Cond=1110, then RegW=1 -> CondExReg=1, RegWrite=1, Flags=0000.
- Flags=0000, Decode with Cond=0000 (EQ), then PCS=1 and RegW=1 -> PCWrite=0, RegWrite=0; with NextPC=1, PCWrite=1.
- Cond=1110, FlagW=11, ALUFlags=0110 in EXECUTE -> Flags=0110 next cycle. Then Decode with Cond=0000 -> CondExReg=1, and MemW=1 gives MemWrite=1.
- Flags=1000, Decode with Cond=1010 (GE, N!=V) -> CondExReg=0. FlagW=11 with ALUFlags=0101 -> Flags stays 1000.
- FlagW=10 passing, ALUFlags=1111, Flags=0011 -> Flags=1111. FlagW=01 passing, ALUFlags=0000 -> Flags=1100.
- COND_SQUASH_CNT_EN: Decode with Cond=1111, three times -> SquashCount=3. Drop reset to 0 mid-count -> SquashCount=0 and CondExReg=0 immediately. Preload at FFFF plus one squash -> stays FFFF.
